// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding and playfield bounds for the pong ball logic
package pong_pkg;
  localparam int POS_W = 3;
  localparam int X_MIN = 1;
  localparam int X_MAX = 6;
  localparam int Y_MIN = 1;
  localparam int Y_PADDLE = 6;
  localparam int Y_OUT = 7;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_t;
endpackage

// File: rtl/tick_divider.sv
// tick_divider: counts 0..divisor-1 while enabled and pulses tick on the last count
module tick_divider #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] divisor,
  output logic         tick
);
  logic [W-1:0] cnt;
  // >= keeps the counter from running past a divisor that shrank mid-period
  assign tick = en && cnt >= divisor - W'(1);
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/ball_motion.sv
// ball_motion: ball FSM and position registers; SPEEDUP_EN enables divisor halving every 4 paddle hits
module ball_motion
  import pong_pkg::*;
#(
  parameter int POS_W = pong_pkg::POS_W,
  parameter int TICK_DIV = 25000000,
  parameter int X_START = 3,
  parameter int Y_START = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir_x,
  input  logic             dir_y,
  output logic [POS_W-1:0] x_pos,
  output logic [POS_W-1:0] y_pos,
  output logic             step,
  output logic             running,
  output logic             game_over
);
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [POS_W-1:0] ONE = POS_W'(1);
  localparam logic [POS_W-1:0] XS = POS_W'(X_START);
  localparam logic [POS_W-1:0] YS = POS_W'(Y_START);
  localparam logic [POS_W-1:0] XMN = POS_W'(X_MIN);
  localparam logic [POS_W-1:0] XMX = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] YMN = POS_W'(Y_MIN);
  localparam logic [POS_W-1:0] YPD = POS_W'(Y_PADDLE);
  localparam logic [POS_W-1:0] YOUT = POS_W'(Y_OUT);
  state_t state;
  logic tick, over_next;
  logic [CW-1:0] div;
  logic [POS_W-1:0] x_next, y_next;
  always_comb begin
    x_next = dir_x ? (x_pos == XMN ? XMN + ONE : x_pos - ONE) : (x_pos == XMX ? XMX - ONE : x_pos + ONE);
    y_next = dir_y ? (y_pos == YMN ? YMN + ONE : y_pos - ONE) : y_pos + ONE;
    over_next = !dir_y && y_pos == YPD;
  end
  tick_divider #(.W(CW)) u_tick (
    .clk(clk),
    .reset(reset),
    .en(state == RUN),
    .clr(state != RUN),
    .divisor(div),
    .tick(tick)
  );
`ifdef SPEEDUP_EN
  localparam int DMIN = TICK_DIV / 8 < 1 ? 1 : TICK_DIV / 8;
  logic [1:0] hits;
  logic hit;
  assign hit = tick && state == RUN && dir_y && y_pos == YPD;
  always_ff @(posedge clk) begin
    if (reset || state == IDLE) begin
      hits <= '0;
      div <= CW'(TICK_DIV);
    end else if (hit) begin
      hits <= hits + 2'd1;
      if (hits == 2'd3) div <= (div >> 1) < CW'(DMIN) ? CW'(DMIN) : div >> 1;
    end
  end
`else
  assign div = CW'(TICK_DIV);
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      x_pos <= XS;
      y_pos <= YS;
      step <= 1'b0;
      running <= 1'b0;
      game_over <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          running <= 1'b1;
        end
        RUN: if (tick) begin
          x_pos <= x_next;
          y_pos <= over_next ? YOUT : y_next;
          step <= 1'b1;
          if (over_next) begin
            state <= OVER;
            running <= 1'b0;
            game_over <= 1'b1;
          end
        end
        OVER: if (start) begin
          state <= IDLE;
          game_over <= 1'b0;
          x_pos <= XS;
          y_pos <= YS;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: random-stimulus bench against a countdown-based behavioural model of the ball
module tb_ball_motion;
  logic clk = 1'b0;
  logic reset, start, dir_x, dir_y;
  logic [2:0] x_pos, y_pos;
  logic step, running, game_over;
  int checks = 0, failures = 0;
  int m_state, mx, my, m_left, m_step, m_div, m_hits;
  always #5 clk = ~clk;
  ball_motion #(.POS_W(3), .TICK_DIV(4), .X_START(3), .Y_START(1)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .dir_x(dir_x),
    .dir_y(dir_y),
    .x_pos(x_pos),
    .y_pos(y_pos),
    .step(step),
    .running(running),
    .game_over(game_over)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  task automatic serve_reload();
    m_state = 0;
    mx = 3;
    my = 1;
    m_div = 4;
    m_hits = 0;
  endtask
  task automatic cycle(input logic r, input logic s, input logic dx, input logic dy);
    reset = r;
    start = s;
    dir_x = dx;
    dir_y = dy;
    m_step = 0;
    if (r) serve_reload();
    else if (m_state == 0) begin
      if (s) begin
        m_state = 1;
        m_left = m_div;
      end
    end else if (m_state == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_step = 1;
`ifdef SPEEDUP_EN
        if (dy && my == 6) begin
          m_hits = (m_hits + 1) % 4;
          if (m_hits == 0) m_div = m_div / 2 < 1 ? 1 : m_div / 2;
        end
`endif
        mx = dx ? (mx == 1 ? 2 : mx - 1) : (mx == 6 ? 5 : mx + 1);
        my = dy ? (my == 1 ? 2 : my - 1) : my + 1;
        if (my == 7) m_state = 2;
        m_left = m_div;
      end
    end else if (s) serve_reload();
    @(posedge clk);
    #1;
    chk("x_pos", x_pos, mx);
    chk("y_pos", y_pos, my);
    chk("step", step, m_step);
    chk("running", running, m_state == 1);
    chk("game_over", game_over, m_state == 2);
  endtask
  initial begin
    serve_reload();
    m_left = 0;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);
    for (int i = 0; i < 4000; i++)
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 9) < 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
